// File: rtl/acc_bus_ctrl.sv
// Accelerator-to-memory bus controller: queues acc requests, issues them in order, returns read data.
// Optional ACC_BUS_PERF_EN adds read/write/stall counters. Latency: acc->mem 1 cycle, mem_rvalid->acc_rvalid 1 cycle.
`ifndef FE_ADDR_W
`define FE_ADDR_W 32
`endif
`ifndef FE_DATA_W
`define FE_DATA_W 256
`endif
`ifndef FE_STRB_W
`define FE_STRB_W (`FE_DATA_W/8)
`endif

module acc_bus_ctrl #(
    parameter int ADDR_W    = `FE_ADDR_W,
    parameter int DATA_W    = `FE_DATA_W,
    parameter int STRB_W    = `FE_STRB_W,
    parameter int REQ_DEPTH = 4,
    parameter int MAX_OUTST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_valid,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [DATA_W-1:0] acc_wdata,
    input  logic [STRB_W-1:0] acc_wstrb,
    output logic              acc_ready,
    output logic [DATA_W-1:0] acc_rdata,
    output logic              acc_rvalid,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
`ifdef ACC_BUS_PERF_EN
    output logic [31:0]       perf_rd_cnt,
    output logic [31:0]       perf_wr_cnt,
    output logic [31:0]       perf_stall_cnt,
`endif
    output logic              busy,
    output logic              err
);

    localparam int PTR_W = $clog2(REQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OW    = 5;

    typedef enum logic {M_IDLE, M_REQ} state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] q_addr  [REQ_DEPTH];
    logic [DATA_W-1:0] q_wdata [REQ_DEPTH];
    logic [STRB_W-1:0] q_wstrb [REQ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [OW-1:0]     outst, outst_nxt;

    logic              fifo_empty, push, pop, fifo_we, load;
    logic              src_vld, src_elig, mem_acc, rd_acc, rv_ok;
    logic [ADDR_W-1:0] src_addr;
    logic [DATA_W-1:0] src_wdata;
    logic [STRB_W-1:0] src_wstrb;

    assign fifo_empty = (count == '0);
    assign acc_ready  = (count < CNT_W'(REQ_DEPTH));
    assign push       = acc_valid && acc_ready;

    // With an empty FIFO the incoming request bypasses the queue so it can issue on the next cycle.
    assign src_vld   = fifo_empty ? push      : 1'b1;
    assign src_addr  = fifo_empty ? acc_addr  : q_addr[rd_ptr];
    assign src_wdata = fifo_empty ? acc_wdata : q_wdata[rd_ptr];
    assign src_wstrb = fifo_empty ? acc_wstrb : q_wstrb[rd_ptr];

    assign mem_valid = (state_q == M_REQ);
    assign mem_acc   = mem_valid && mem_ready;
    assign rd_acc    = mem_acc && (mem_wstrb == '0);
    assign rv_ok     = mem_rvalid && (outst != '0);
    assign outst_nxt = outst + OW'(rd_acc) - OW'(rv_ok);

    // Eligibility looks at the outstanding count as it will be after this cycle's accept/return.
    assign src_elig = src_vld && ((src_wstrb != '0) || (outst_nxt < OW'(MAX_OUTST)));

    assign fifo_we = push && !(load && fifo_empty);
    assign pop     = load && !fifo_empty;
    assign busy    = !fifo_empty || mem_valid || (outst != '0);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            M_IDLE: begin
                if (src_elig) begin
                    load    = 1'b1;
                    state_d = M_REQ;
                end
            end
            M_REQ: begin
                if (mem_ready) begin
                    if (src_elig) begin
                        load = 1'b1;
                    end else begin
                        state_d = M_IDLE;
                    end
                end
            end
            default: state_d = M_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (fifo_we) begin
            q_addr[wr_ptr]  <= acc_addr;
            q_wdata[wr_ptr] <= acc_wdata;
            q_wstrb[wr_ptr] <= acc_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= M_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            outst      <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            acc_rvalid <= 1'b0;
            acc_rdata  <= '0;
            err        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fifo_we) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(fifo_we) - CNT_W'(pop);
            outst <= outst_nxt;
            if (load) begin
                mem_addr  <= src_addr;
                mem_wdata <= src_wdata;
                mem_wstrb <= src_wstrb;
            end
            acc_rvalid <= rv_ok;
            if (rv_ok) acc_rdata <= mem_rdata;
            // A return with nothing outstanding is dropped and latched as a protocol error.
            if (mem_rvalid && (outst == '0)) err <= 1'b1;
        end
    end

`ifdef ACC_BUS_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_rd_cnt    <= '0;
            perf_wr_cnt    <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (rd_acc)                  perf_rd_cnt    <= perf_rd_cnt + 32'd1;
            if (mem_acc && !rd_acc)      perf_wr_cnt    <= perf_wr_cnt + 32'd1;
            if (mem_valid && !mem_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_acc_bus_ctrl.sv
// Directed bench for acc_bus_ctrl: issue latency, backpressure, read limit, ordering, err and reset.
module tb_acc_bus_ctrl;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 256;
    localparam int STRB_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              acc_valid;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [STRB_W-1:0] acc_wstrb;
    logic              acc_ready;
    logic [DATA_W-1:0] acc_rdata;
    logic              acc_rvalid;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;
    logic              busy;
    logic              err;
`ifdef ACC_BUS_PERF_EN
    logic [31:0]       perf_rd_cnt, perf_wr_cnt, perf_stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    acc_bus_ctrl dut (
        .clk(clk), .rst(rst),
        .acc_valid(acc_valid), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
        .acc_wstrb(acc_wstrb), .acc_ready(acc_ready), .acc_rdata(acc_rdata),
        .acc_rvalid(acc_rvalid), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
`ifdef ACC_BUS_PERF_EN
        .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
        .busy(busy), .err(err)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [255:0] d, input logic [31:0] s);
        acc_valid = v;
        acc_addr  = a;
        acc_wdata = d;
        acc_wstrb = s;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nacc;
        int n_iss;
        rst = 1'b1; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        drive(1'b0, 0, 0, 0);
        step; step;
        chk("rst_acc_ready", acc_ready, 1);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_acc_rvalid", acc_rvalid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst = 1'b0;

        // single read with 1-cycle issue latency and 1-cycle return
        mem_ready = 1'b1;
        drive(1'b1, 32'h10, 0, 0);
        #1 chk("rd_acc_ready", acc_ready, 1);
        step;
        drive(1'b0, 0, 0, 0);
        chk("rd_mem_valid", mem_valid, 1);
        chk("rd_mem_addr", mem_addr, 32'h10);
        chk("rd_mem_wstrb", mem_wstrb, 0);
        step;
        chk("rd_mem_valid_drop", mem_valid, 0);
        chk("rd_busy_outst", busy, 1);
        step; step;
        mem_rvalid = 1'b1; mem_rdata = 256'hAB;
        step;
        mem_rvalid = 1'b0; mem_rdata = '0;
        chk("rd_acc_rvalid", acc_rvalid, 1);
        chk("rd_acc_rdata", acc_rdata, 256'hAB);
        chk("rd_busy_done", busy, 0);
        step;
        chk("rd_rvalid_pulse", acc_rvalid, 0);
        chk("rd_rdata_hold", acc_rdata, 256'hAB);

        // backpressure: one request in flight plus a full FIFO
        mem_ready = 1'b0;
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h40 + nacc, nacc, 32'h1);
            #1;
            if (acc_ready) nacc++;
            step;
        end
        drive(1'b0, 0, 0, 0);
        #1;
        chk("bp_accepted", nacc, 5);
        chk("bp_acc_ready_low", acc_ready, 0);
        chk("bp_mem_addr_stable", mem_addr, 32'h40);
        chk("bp_mem_valid", mem_valid, 1);
        mem_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step;
            chk("bp_order_vld", mem_valid, 1);
            chk("bp_order_addr", mem_addr, 32'h40 + k);
            chk("bp_order_data", mem_wdata, k);
        end
        step;
        chk("bp_idle", mem_valid, 0);
        chk("bp_busy", busy, 0);

        // outstanding-read limit
        n_iss = 0;
        for (int c = 0; c < 10; c++) begin
            if (c < 6) drive(1'b1, 32'h80 + c, 0, 0);
            else       drive(1'b0, 0, 0, 0);
            step;
            if (mem_valid && mem_ready) n_iss++;
        end
        drive(1'b0, 0, 0, 0);
        chk("lim_issued", n_iss, 4);
        chk("lim_stalled", mem_valid, 0);
        mem_rvalid = 1'b1; mem_rdata = 256'h111;
        step;
        mem_rvalid = 1'b0;
        chk("lim_5th_vld", mem_valid, 1);
        chk("lim_5th_addr", mem_addr, 32'h84);
        chk("lim_rdata", acc_rdata, 256'h111);
        step;
        chk("lim_6th_blocked", mem_valid, 0);
        mem_rvalid = 1'b1;
        step;
        chk("lim_6th_addr", mem_addr, 32'h85);
        step; step; step; step;
        mem_rvalid = 1'b0;
        chk("lim_drained", busy, 0);
        chk("lim_no_err", err, 0);

        // read then write: write issues while read outstanding
        drive(1'b1, 32'h20, 0, 0);
        step;
        chk("rw_rd_addr", mem_addr, 32'h20);
        chk("rw_rd_strb", mem_wstrb, 0);
        drive(1'b1, 32'h21, 256'd7, 32'h0000000F);
        step;
        drive(1'b0, 0, 0, 0);
        chk("rw_wr_vld", mem_valid, 1);
        chk("rw_wr_addr", mem_addr, 32'h21);
        chk("rw_wr_strb", mem_wstrb, 32'h0000000F);
        chk("rw_wr_data", mem_wdata, 256'd7);
        step;
        chk("rw_busy_outst", busy, 1);
        mem_rvalid = 1'b1; mem_rdata = 256'h55;
        step;
        mem_rvalid = 1'b0;
        chk("rw_rdata", acc_rdata, 256'h55);
        chk("rw_busy_done", busy, 0);

        // stray return sets sticky err
        mem_rvalid = 1'b1; mem_rdata = 256'h99;
        step;
        mem_rvalid = 1'b0;
        chk("err_set", err, 1);
        chk("err_no_rvalid", acc_rvalid, 0);
        chk("err_rdata_hold", acc_rdata, 256'h55);
        step; step;
        chk("err_sticky", err, 1);

        // reset with 2 reads outstanding and 2 queued
        drive(1'b1, 32'hA0, 0, 0); step;
        drive(1'b1, 32'hA1, 0, 0); step;
        drive(1'b0, 0, 0, 0);      step;
        mem_ready = 1'b0;
        drive(1'b1, 32'hA2, 0, 0); step;
        drive(1'b1, 32'hA3, 0, 0); step;
        drive(1'b1, 32'hA4, 0, 0); step;
        drive(1'b0, 0, 0, 0);
        chk("mid_busy", busy, 1);
        chk("mid_err", err, 1);
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("r2_acc_ready", acc_ready, 1);
        chk("r2_busy", busy, 0);
        chk("r2_mem_valid", mem_valid, 0);
        chk("r2_mem_addr", mem_addr, 0);
        chk("r2_mem_wdata", mem_wdata, 0);
        chk("r2_mem_wstrb", mem_wstrb, 0);
        chk("r2_err", err, 0);
        chk("r2_acc_rdata", acc_rdata, 0);
        chk("r2_acc_rvalid", acc_rvalid, 0);
        mem_rvalid = 1'b1;
        step;
        mem_rvalid = 1'b0;
        chk("r2_late_err", err, 1);
        chk("r2_late_rvalid", acc_rvalid, 0);
        chk("r2_late_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
